multdiv_issue_ctrl: RTL and testbench

Requester-side controller for the slow multi-cycle multiply/divide unit. It accepts one operation from the execute stage over a valid/ready handshake and drives operands, operator and enables to the multdiv unit, holding them stable. It waits for the unit's valid, captures the result and presents it on a valid/ready response port. It also short-circuits divide-by-zero, enforces a timeout and supports a flush.

---
 rtl/multdiv_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multi-cycle multiply/divide unit: accepts one operation,
// holds operands and enables steady, then returns the result or a timeout error.
module multdiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_operator_i,
  input  logic [1:0]       req_signed_mode_i,
  input  logic [31:0]      req_op_a_i,
  input  logic [31:0]      req_op_b_i,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic [1:0]       operator_o,
  output logic [1:0]       signed_mode_o,
  output logic [31:0]      op_a_o,
  output logic [31:0]      op_b_o,
  input  logic             md_valid_i,
  input  logic [31:0]      md_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] busy_cycles_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_r, state_s;
  logic [1:0]        operator_r, operator_s;
  logic [1:0]        signed_mode_r, signed_mode_s;
  logic [31:0]       op_a_r, op_a_s;
  logic [31:0]       op_b_r, op_b_s;
  logic [31:0]       rsp_data_r, rsp_data_s;
  logic              rsp_err_r, rsp_err_s;
  logic [CNT_W-1:0]  busy_r, busy_s;

  // Division by zero is answered locally: all-ones quotient, remainder equals dividend.
  function automatic logic [31:0] div_zero_result(input logic [1:0] op, input logic [31:0] a);
    if (op[0]) begin
      div_zero_result = a;
    end else begin
      div_zero_result = 32'hFFFF_FFFF;
    end
  endfunction

  // Next-state and next-value logic for the control FSM and its datapath registers.
  always_comb begin
    state_s       = state_r;
    operator_s    = operator_r;
    signed_mode_s = signed_mode_r;
    op_a_s        = op_a_r;
    op_b_s        = op_b_r;
    rsp_data_s    = rsp_data_r;
    rsp_err_s     = rsp_err_r;
    busy_s        = busy_r;

    if (flush_i) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            operator_s    = req_operator_i;
            signed_mode_s = req_signed_mode_i;
            op_a_s        = req_op_a_i;
            op_b_s        = req_op_b_i;
            busy_s        = {CNT_W{1'b0}};
            if (req_operator_i[1] && (req_op_b_i == 32'd0)) begin
              rsp_data_s = div_zero_result(req_operator_i, req_op_a_i);
              rsp_err_s  = 1'b0;
              state_s    = ST_RESP;
            end else begin
              state_s = ST_BUSY;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (busy_r != CNT_MAX) begin
            busy_s = busy_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            busy_s = busy_r;
          end
          if (md_valid_i) begin
            rsp_data_s = md_result_i;
            rsp_err_s  = 1'b0;
            state_s    = ST_RESP;
          end else if (busy_r == TIMEOUT_LAST) begin
            rsp_data_s = 32'd0;
            rsp_err_s  = 1'b1;
            state_s    = ST_RESP;
          end else begin
            state_s = ST_BUSY;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RESP;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      operator_r    <= 2'd0;
      signed_mode_r <= 2'd0;
      op_a_r        <= 32'd0;
      op_b_r        <= 32'd0;
      rsp_data_r    <= 32'd0;
      rsp_err_r     <= 1'b0;
      busy_r        <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      operator_r    <= operator_s;
      signed_mode_r <= signed_mode_s;
      op_a_r        <= op_a_s;
      op_b_r        <= op_b_s;
      rsp_data_r    <= rsp_data_s;
      rsp_err_r     <= rsp_err_s;
      busy_r        <= busy_s;
    end
  end

  assign req_ready_o   = (state_r == ST_IDLE);
  assign rsp_valid_o   = (state_r == ST_RESP);
  assign mult_en_o     = (state_r == ST_BUSY) & ~operator_r[1];
  assign div_en_o      = (state_r == ST_BUSY) &  operator_r[1];
  assign operator_o    = operator_r;
  assign signed_mode_o = signed_mode_r;
  assign op_a_o        = op_a_r;
  assign op_b_o        = op_b_r;
  assign rsp_data_o    = rsp_data_r;
  assign rsp_err_o     = rsp_err_r;
  assign busy_cycles_o = busy_r;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl: a scoreboard queue holds expected responses,
// a monitor pops them on each response handshake; stimulus also checks timing directly.
module tb_multdiv_issue_ctrl;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_operator_i;
  logic [1:0]       req_signed_mode_i;
  logic [31:0]      req_op_a_i;
  logic [31:0]      req_op_b_i;
  logic             mult_en_o;
  logic             div_en_o;
  logic [1:0]       operator_o;
  logic [1:0]       signed_mode_o;
  logic [31:0]      op_a_o;
  logic [31:0]      op_b_o;
  logic             md_valid_i;
  logic [31:0]      md_result_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic             rsp_err_o;
  logic [CNT_W-1:0] busy_cycles_o;

  multdiv_issue_ctrl #(.TIMEOUT_CYCLES(40), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o),
    .operator_o(operator_o), .signed_mode_o(signed_mode_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o),
    .md_valid_i(md_valid_i), .md_result_i(md_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .busy_cycles_o(busy_cycles_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [1:0] sm,
                           input logic [31:0] a, input logic [31:0] b);
    req_operator_i    = op;
    req_signed_mode_i = sm;
    req_op_a_i        = a;
    req_op_b_i        = b;
    req_valid_i       = 1'b1;
  endtask

  // Scoreboard monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got data 0x%08h err %0d with empty scoreboard",
                 rsp_data_o, rsp_err_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data_o, e[31:0]);
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e[32]});
      end
    end
  end

  initial begin
    int cnt_m;
    int cnt_d;
    logic hold_ok;

    rst_i = 1'b1; flush_i = 1'b0; md_valid_i = 1'b0; md_result_i = 32'd0;
    rsp_ready_i = 1'b1;
    drive_req(2'd0, 2'd0, 32'd7, 32'd6);

    // Reset with a pending request: nothing is accepted.
    repeat (3) step();
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_mult_en", {31'd0, mult_en_o}, 32'd0);
    chk("rst_div_en", {31'd0, div_en_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_op_a", op_a_o, 32'd0);
    chk("rst_busy", {26'd0, busy_cycles_o}, 32'd0);

    // MULL 7*6, unit answers after 33 cycles.
    step();
    rst_i = 1'b0;
    exp_q.push_back({1'b0, 32'd42});
    step();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("mull_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("mull_op_a", op_a_o, 32'd7);
    chk("mull_op_b", op_b_o, 32'd6);
    cnt_m = int'(mult_en_o);
    cnt_d = int'(div_en_o);
    repeat (31) begin
      step();
      @(negedge clk);
      cnt_m += int'(mult_en_o);
      cnt_d += int'(div_en_o);
    end
    step();
    md_valid_i = 1'b1; md_result_i = 32'd42;
    @(negedge clk);
    cnt_m += int'(mult_en_o);
    cnt_d += int'(div_en_o);
    step();
    md_valid_i = 1'b0; md_result_i = 32'd0;
    @(negedge clk);
    cnt_m += int'(mult_en_o);
    chk("mull_en_cycles", cnt_m, 32'd33);
    chk("mull_div_en_cycles", cnt_d, 32'd0);
    chk("mull_busy_cycles", {26'd0, busy_cycles_o}, 32'd33);
    chk("mull_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);

    // DIV by zero: immediate all-ones response, no enables.
    step();
    drive_req(2'd2, 2'd3, 32'd100, 32'd0);
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    step();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("divz_en", {30'd0, mult_en_o, div_en_o}, 32'd0);
    chk("divz_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);

    // REM by zero: remainder is the dividend.
    step();
    drive_req(2'd3, 2'd0, 32'd100, 32'd0);
    exp_q.push_back({1'b0, 32'd100});
    step();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("remz_en", {30'd0, mult_en_o, div_en_o}, 32'd0);
    chk("remz_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);

    // DIV that never completes: timeout after 40 BUSY cycles, response held while not ready.
    step();
    rsp_ready_i = 1'b0;
    drive_req(2'd2, 2'd1, 32'd50, 32'd7);
    exp_q.push_back({1'b1, 32'd0});
    step();
    req_valid_i = 1'b0;
    cnt_d = 0;
    repeat (40) begin
      @(negedge clk);
      cnt_d += int'(div_en_o);
      step();
    end
    @(negedge clk);
    chk("to_div_en_cycles", cnt_d, 32'd40);
    chk("to_div_en_low", {31'd0, div_en_o}, 32'd0);
    chk("to_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err_o}, 32'd1);
    chk("to_busy_cycles", {26'd0, busy_cycles_o}, 32'd40);
    chk("to_signed_mode", {30'd0, signed_mode_o}, 32'd1);
    hold_ok = 1'b1;
    repeat (5) begin
      step();
      @(negedge clk);
      if (!(rsp_valid_o && rsp_data_o == 32'd0 && rsp_err_o && !req_ready_o)) hold_ok = 1'b0;
    end
    chk("to_hold_stable", {31'd0, hold_ok}, 32'd1);
    step();
    rsp_ready_i = 1'b1;
    step();
    @(negedge clk);
    chk("to_back_idle", {31'd0, req_ready_o}, 32'd1);

    // Flush on BUSY cycle 10 with md_valid in the same cycle: no response.
    drive_req(2'd1, 2'd0, 32'd3, 32'd5);
    step();
    req_valid_i = 1'b0;
    repeat (9) step();
    flush_i = 1'b1; md_valid_i = 1'b1; md_result_i = 32'd123;
    step();
    flush_i = 1'b0; md_valid_i = 1'b0; md_result_i = 32'd0;
    @(negedge clk);
    chk("flush_en", {30'd0, mult_en_o, div_en_o}, 32'd0);
    chk("flush_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("flush_req_ready", {31'd0, req_ready_o}, 32'd1);

    // md_valid in IDLE is ignored.
    step();
    md_valid_i = 1'b1; md_result_i = 32'd77;
    step();
    md_valid_i = 1'b0; md_result_i = 32'd0;
    @(negedge clk);
    chk("idle_md_ignored", {31'd0, rsp_valid_o}, 32'd0);

    // New request after flush completes normally.
    step();
    drive_req(2'd0, 2'd0, 32'd2, 32'd3);
    exp_q.push_back({1'b0, 32'd6});
    step();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("post_flush_mult_en", {31'd0, mult_en_o}, 32'd1);
    repeat (3) step();
    md_valid_i = 1'b1; md_result_i = 32'd6;
    step();
    md_valid_i = 1'b0; md_result_i = 32'd0;
    @(negedge clk);
    chk("post_flush_busy", {26'd0, busy_cycles_o}, 32'd4);

    repeat (4) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
